// File: rtl/sub_bytes_step.sv
// AES SubBytes round step: substitutes the 16 bytes of a 128-bit state serially,
// one byte per clock through a single forward S-box, behind a start/finish handshake.
module sub_bytes_step (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] in,
  input  logic [127:0] key,
  output logic         finish,
  output logic [127:0] subbytesstep
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX_TABLE[{~a, 3'b000} +: 8];
  endfunction

  logic [1:0]   state_q, state_d;
  logic [127:0] work_q, work_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         finish_q, finish_d;
  logic [127:0] result_q, result_d;
  logic [7:0]   sub_byte;

  // The key only exists for port uniformity with the other round steps.
  logic unused_key;
  assign unused_key = ^key;

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    finish_d = finish_q;
    result_d = result_q;
    sub_byte = sbox(work_q[{cnt_q, 3'b000} +: 8]);
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d   = in;
          cnt_d    = 4'd0;
          finish_d = 1'b0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        work_d[{cnt_q, 3'b000} +: 8] = sub_byte;
        cnt_d = cnt_q + 4'd1;
        // Publish the whole word at once so partial results never reach the output.
        if (cnt_q == 4'd15) begin
          result_d = work_d;
          finish_d = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      finish_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      finish_q <= finish_d;
      result_q <= result_d;
    end
  end

  assign finish       = finish_q;
  assign subbytesstep = result_q;

endmodule

// File: tb/tb_sub_bytes_step.sv
// Randomized bench for sub_bytes_step; the reference S-box is derived from the
// GF(2^8) inverse plus affine transform rather than a lookup table.
module tb_sub_bytes_step;

  logic         clk = 1'b0;
  logic         rst_r = 1'b0;
  logic         start_r = 1'b0;
  logic [127:0] in_r = '0;
  logic [127:0] key_r = '0;
  logic         finish;
  logic [127:0] subbytesstep;

  int total = 0;
  int bad = 0;
  logic [127:0] exp_hold = '0;

  sub_bytes_step dut (
    .clk          (clk),
    .rst          (rst_r),
    .start        (start_r),
    .in           (in_r),
    .key          (key_r),
    .finish       (finish),
    .subbytesstep (subbytesstep)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%032h want=%032h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    for (int c = 1; c < 256; c++)
      if (gmul(a, 8'(c)) == 8'h01) inv = 8'(c);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_ref(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox_ref(s[8*k +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 = two-cycle start pulse, 1 = start held through finish, 2 = start/in toggled while busy
  task automatic do_op(input logic [127:0] din, input logic [127:0] k, input int mode,
                       output logic [127:0] res);
    int n;
    logic [127:0] exp;
    exp = sub_ref(din);
    in_r = din;
    key_r = k;
    start_r = 1'b1;
    tick();
    check("fin_clr_on_capture", {127'b0, finish}, 128'd0);
    n = 0;
    while (!finish && n < 40) begin
      if (mode == 2) begin
        in_r = rand128();
        start_r = 1'($urandom_range(0, 1));
      end else if (mode == 0 && n >= 1) begin
        start_r = 1'b0;
      end
      if (n == 8) check("out_stable_busy", subbytesstep, exp_hold);
      tick();
      n++;
    end
    check("latency", 128'(n), 128'd16);
    check("result", subbytesstep, exp);
    exp_hold = exp;
    if (mode == 1) begin
      tick();
      tick();
      check("done_hold_fin", {127'b0, finish}, 128'd1);
    end
    start_r = 1'b0;
    tick();
    tick();
    check("idle_fin_held", {127'b0, finish}, 128'd1);
    check("idle_res_held", subbytesstep, exp);
    res = subbytesstep;
  endtask

  initial begin
    logic [127:0] r, r0, r1;
    #12;
    check("rst_fin", {127'b0, finish}, 128'd0);
    check("rst_res", subbytesstep, 128'd0);
    rst_r = 1'b1;
    tick();

    do_op(128'h2a179373117e3de9969f402ee2bec16b, 128'h3c4fcf098815f7aba6d2ae2816157e2b, 0, r);
    check("vec1_const", r, 128'he5f0dc8f82f3271e90db093198ae787f);

    do_op(128'h518eaf45ac6fb79e9cac031e578a2dae, rand128(), 1, r);
    check("vec2_const", r, 128'hd119796e91a8a90bde917b725b7ed8e4);

    do_op(128'hef520a1a19c1fbe511e45ca3461cc830, rand128(), 0, r);
    check("b2b_a_const", r, 128'hdf0067a2d4780fd982694a0a5a9ce804);
    do_op(128'h10376ce67b412bad179b4fdf45249ff6, rand128(), 0, r);
    check("b2b_b_const", r, 128'hca9a508e2183f195f014849e6e36db42);

    do_op(128'h2a179373117e3de9969f402ee2bec16b, '0, 0, r0);
    do_op(128'h2a179373117e3de9969f402ee2bec16b, '1, 1, r1);
    check("key_indep_0", r0, 128'he5f0dc8f82f3271e90db093198ae787f);
    check("key_indep_1", r1, r0);

    do_op('0, rand128(), 2, r);
    check("all_zero", r, {16{8'h63}});
    do_op('1, rand128(), 2, r);
    check("all_ones", r, {16{8'h16}});

    for (int i = 0; i < 6; i++) do_op(rand128(), rand128(), int'($urandom_range(0, 2)), r);

    // Abort mid-operation with an asynchronous reset.
    in_r = rand128();
    start_r = 1'b1;
    tick();
    start_r = 1'b0;
    repeat (5) tick();
    #2;
    rst_r = 1'b0;
    #1;
    check("midrst_fin", {127'b0, finish}, 128'd0);
    check("midrst_res", subbytesstep, 128'd0);
    exp_hold = '0;
    tick();
    rst_r = 1'b1;
    tick();
    check("post_rst_idle", {127'b0, finish}, 128'd0);
    do_op(rand128(), rand128(), 0, r);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
